// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity encodings, receive FSM states,
// tuser bit positions and the parameter legality check used at elaboration.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int TUSER_PERR = 0;
  localparam int TUSER_FERR = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int clks_per_bit, input int data_bits,
                                      input int parity, input int stop_bits,
                                      input int fifo_depth);
    return (clks_per_bit >= 4) &&
           (data_bits >= 5) && (data_bits <= 9) &&
           (parity >= PAR_NONE) && (parity <= PAR_EVEN) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (fifo_depth >= 2) && is_pow2(fifo_depth);
  endfunction

endpackage

// File: rtl/uart_rx_axis_if.sv
// AXI4-Stream output bundle of the UART receiver; tuser carries the per-word
// parity/framing error flags.
interface uart_rx_axis_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tdata;
  logic [1:0]           tuser;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, output tuser, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with a push/full write side and an AXIS valid/ready read side.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module axis_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic [WIDTH-1:0] m_tdata_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, pop, wr_en;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop    = !empty && m_tready_i;
  assign wr_en  = push_i && (!full_o || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: storage has no reset; nothing reads it while empty, so resetting it would only cost flops.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  // Forcing zero while empty gives the reset value and hides stale entries.
  assign m_tvalid_o = !empty;
  assign m_tdata_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_axis.sv
// Parametrised UART receiver: input synchroniser, bit-timing counter and frame FSM,
// delivering {error flags, data} words through a small FIFO as an AXIS master.
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            rx,
  uart_rx_axis_if.master  out,
  output logic            overrun
);

  if (!params_legal(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH)) begin : g_param_check
    $error("uart_rx_axis: illegal parameter combination");
  end

  localparam int              CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   HALF_LOAD  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   BIT_LOAD   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [3:0]      LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic            LAST_STOP  = 1'(STOP_BITS - 1);
  localparam logic            PAR_EXPECT = (PARITY == PAR_ODD);

  // Synchroniser and edge history; all idle high so reset never looks like a start edge.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the three stages shift together, one stage per clock.
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tick;
  logic                 push;
  logic [1:0]           push_user;

  assign tick = (cnt_q == '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no branch can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    stop_cnt_d = stop_cnt_q;
    push       = 1'b0;
    push_user  = '0;

    if (state_q != ST_IDLE && !tick) cnt_d = cnt_q - CNT_ONE;

    case (state_q)
      ST_IDLE: begin
        // Needs a genuine 1->0 transition, so a line stuck low cannot retrigger.
        if (rx_prev_q && !rx_sync_q) begin
          cnt_d   = HALF_LOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (rx_sync_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_DATA;
            cnt_d      = BIT_LOAD;
            bit_cnt_d  = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            stop_cnt_d = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          data_d = {rx_sync_q, data_q[DATA_BITS-1:1]};
          cnt_d  = BIT_LOAD;
          if (bit_cnt_q == LAST_DATA) begin
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          perr_d  = ((^data_q) ^ rx_sync_q) != PAR_EXPECT;
          cnt_d   = BIT_LOAD;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            push                  = 1'b1;
            push_user[TUSER_PERR] = perr_q;
            push_user[TUSER_FERR] = ferr_q | ~rx_sync_q;
            state_d               = ST_IDLE;
          end else begin
            ferr_d     = ferr_q | ~rx_sync_q;
            stop_cnt_d = 1'b1;
            cnt_d      = BIT_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic                   fifo_full, fifo_valid, pop, overrun_q;
  logic [DATA_BITS+1:0]   fifo_dout;

  axis_sync_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (aclk),
    .rst_n       (aresetn),
    .push_i      (push),
    .push_data_i ({push_user, data_q}),
    .full_o      (fifo_full),
    .m_tvalid_o  (fifo_valid),
    .m_tready_i  (out.tready),
    .m_tdata_o   (fifo_dout)
  );

  assign pop        = fifo_valid && out.tready;
  assign out.tvalid = fifo_valid;
  assign out.tdata  = fifo_dout[DATA_BITS-1:0];
  assign out.tuser  = fifo_dout[DATA_BITS +: 2];

  // A word finishing into a full FIFO with no pop that cycle is lost.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) overrun_q <= 1'b0;
    else          overrun_q <= push && fifo_full && !pop;
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Self-checking bench for uart_rx_axis: a cycle-timed frame scoreboard derived from
// the sampling formula, plus directed scenarios with hand-computed expectations.
module tb_uart_rx_axis;

  localparam int C     = 16;
  localparam int D     = 8;
  localparam int P     = 2;
  localparam int S     = 1;
  localparam int DEPTH = 4;
  localparam int H     = C / 2;
  localparam int KLAST = D + 1 + S;
  // Pin edge driven after clock edge n0 -> word visible from edge n0 + LAT (171 here).
  localparam int LAT   = 3 + H + KLAST * C;

  logic aclk = 1'b0;
  logic aresetn;
  logic rx;
  logic overrun;

  always #5 aclk = ~aclk;

  uart_rx_axis_if #(.DATA_BITS(D)) bus ();

  uart_rx_axis #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (D),
    .PARITY       (P),
    .STOP_BITS    (S),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .rx      (rx),
    .out     (bus),
    .overrun (overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge aclk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard model ----------------
  typedef struct {
    int            edge_n;
    logic [D+1:0]  word;   // {ferr, perr, data}
  } pend_t;

  pend_t        pend_q[$];
  logic [D+1:0] mq[$];
  bit           prev_pop = 1'b0;
  bit           prev_tv  = 1'b0;
  int           rise_cyc = -1, fall_cyc = -1, ovr_cyc = -1;
  int           ovr_seen = 0, n_words = 0;
  logic [D-1:0] cap_data = '0;
  logic [1:0]   cap_user = '0;

  always @(negedge aclk) begin : model_cmp
    int size_before;
    bit exp_ovr;
    exp_ovr = 1'b0;
    if (!aresetn) begin
      mq.delete();
      pend_q.delete();
      prev_pop = 1'b0;
      check("rst_tvalid",  {31'd0, bus.tvalid}, 32'd0);
      check("rst_tdata",   {24'd0, bus.tdata},  32'd0);
      check("rst_tuser",   {30'd0, bus.tuser},  32'd0);
      check("rst_overrun", {31'd0, overrun},    32'd0);
    end else begin
      size_before = mq.size();
      if (prev_pop) void'(mq.pop_front());
      while (pend_q.size() > 0 && pend_q[0].edge_n <= cyc) begin
        if (size_before < DEPTH || prev_pop) mq.push_back(pend_q[0].word);
        else exp_ovr = 1'b1;
        void'(pend_q.pop_front());
      end
      check("tvalid",  {31'd0, bus.tvalid}, {31'd0, mq.size() > 0});
      check("overrun", {31'd0, overrun},    {31'd0, exp_ovr});
      if (mq.size() > 0) begin
        check("tdata", {24'd0, bus.tdata}, {24'd0, mq[0][D-1:0]});
        check("tuser", {30'd0, bus.tuser}, {30'd0, mq[0][D+1:D]});
      end
      prev_pop = (mq.size() > 0) && bus.tready;
    end
    if (bus.tvalid && !prev_tv) begin
      rise_cyc = cyc;
      cap_data = bus.tdata;
      cap_user = bus.tuser;
    end
    if (!bus.tvalid && prev_tv) fall_cyc = cyc;
    if (overrun) begin
      ovr_seen++;
      ovr_cyc = cyc;
    end
    if (bus.tvalid && bus.tready) n_words++;
    prev_tv = bus.tvalid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (C) tick();
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [D-1:0] d, input logic par, input logic stop,
                            output int n0);
    logic perr;
    perr = ((^d) ^ par) != 1'b0;   // even parity: data plus parity bit must XOR to 0
    n0 = cyc;
    pend_q.push_back('{edge_n: n0 + LAT, word: {~stop, perr, d}});
    drive_bit(1'b0);
    for (int i = 0; i < D; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n0, n0_last, w0;
    aresetn    = 1'b0;
    rx         = 1'b1;
    bus.tready = 1'b1;
    repeat (5) tick();
    aresetn = 1'b1;
    idle(20);

    // Valid frame 0xA5, even parity bit 0.
    send_frame(8'hA5, 1'b0, 1'b1, n0);
    idle(10);
    check("valid_latency", rise_cyc - n0, 32'd171);
    check("valid_pulse",   fall_cyc - rise_cyc, 32'd1);
    check("valid_data",    {24'd0, cap_data}, 32'h0000_00A5);
    check("valid_user",    {30'd0, cap_user}, 32'd0);

    // Parity error: 0xA5 with parity bit 1.
    send_frame(8'hA5, 1'b1, 1'b1, n0);
    idle(10);
    check("perr_data", {24'd0, cap_data}, 32'h0000_00A5);
    check("perr_user", {30'd0, cap_user}, 32'd1);

    // Framing error: 0x3C, stop bit 0, line then held low for 40 cycles.
    w0 = n_words;
    send_frame(8'h3C, 1'b0, 1'b0, n0);
    rx = 1'b0;
    repeat (40) tick();
    check("ferr_words", n_words, w0 + 1);
    check("ferr_data",  {24'd0, cap_data}, 32'h0000_003C);
    check("ferr_user",  {30'd0, cap_user}, 32'd2);
    idle(30);
    check("ferr_no_retrigger", n_words, w0 + 1);

    // Glitch: 4 low cycles must not produce a word, then a clean frame still decodes.
    w0 = n_words;
    rx = 1'b0;
    repeat (4) tick();
    idle(200);
    check("glitch_words",  n_words, w0);
    check("glitch_tvalid", {31'd0, bus.tvalid}, 32'd0);
    send_frame(8'hC3, 1'b0, 1'b1, n0);
    idle(10);
    check("post_glitch_latency", rise_cyc - n0, 32'd171);
    check("post_glitch_data",    {24'd0, cap_data}, 32'h0000_00C3);

    // Overrun: five back-to-back frames with the sink stalled.
    bus.tready = 1'b0;
    w0 = ovr_seen;
    for (int i = 1; i <= 5; i++) begin
      logic [D-1:0] d;
      d = D'(i);
      send_frame(d, ^d, 1'b1, n0_last);
    end
    idle(30);
    check("ovr_count",  ovr_seen - w0, 32'd1);
    check("ovr_timing", ovr_cyc - n0_last, 32'd171);
    bus.tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge aclk);
      check("drain_valid", {31'd0, bus.tvalid}, 32'd1);
      check("drain_data",  {24'd0, bus.tdata},  i);
    end
    @(negedge aclk);
    check("drain_empty", {31'd0, bus.tvalid}, 32'd0);
    tick();

    // Reset mid-frame, with a stalled word already queued; both must vanish.
    bus.tready = 1'b0;
    send_frame(8'h33, 1'b0, 1'b1, n0);
    rx = 1'b0;
    repeat (C * 4 + H) tick();
    aresetn = 1'b0;
    rx      = 1'b1;
    repeat (3) tick();
    check("rst_mid_tvalid", {31'd0, bus.tvalid}, 32'd0);
    aresetn = 1'b1;
    idle(20);
    check("rst_fifo_flushed", {31'd0, bus.tvalid}, 32'd0);
    bus.tready = 1'b1;
    w0 = n_words;
    send_frame(8'h5A, 1'b0, 1'b1, n0);
    idle(30);
    check("rst_words", n_words, w0 + 1);
    check("rst_data",  {24'd0, cap_data}, 32'h0000_005A);
    check("rst_user",  {30'd0, cap_user}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis.md
# uart_rx_axis

Parametrised UART receiver with AXI4-Stream master output and an internal receive FIFO. It generalises the fixed 8N1 receive path used by the LED demo top level. It adds configurable word length, parity, stop bits and baud divisor, and reports per-word error flags. Backpressure is absorbed by a FIFO with overrun reporting. It sits directly behind the RX pin; the on-chip input synchroniser means no external synchronisation is needed.

## Interface
Parameters:
- CLKS_PER_BIT, 16, aclk cycles per UART bit; legal range ≥ 4.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 4, receive FIFO entries; power of 2, ≥ 2.

Ports:
- aclk, in, 1, single clock; all logic rises on posedge.
- aresetn, in, 1, asynchronous active-low reset.
- rx, in, 1, raw asynchronous UART line; idle high.
- out_tdata, out, DATA_BITS, received word, LSB = first data bit.
- out_tuser, out, 2, bit0 parity error, bit1 framing error for the word in out_tdata.
- out_tvalid, out, 1, FIFO non-empty.
- out_tready, in, 1, downstream accept.
- overrun, out, 1, one-cycle pulse when a completed word is dropped because the FIFO is full.

## Operation
- rx passes through a 2-FF synchroniser; both stages reset to 1.
- Receive FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On a synchronised falling edge (previous 1, current 0), load the bit counter with floor(CLKS_PER_BIT/2)−1 and go to START.
  - A line held low does not retrigger reception.
- START: at the half-bit point, rx=1 is a false start; return to IDLE and push nothing. rx=0 goes to DATA, counter reloaded with CLKS_PER_BIT−1.
- DATA:
  - Sample once per CLKS_PER_BIT cycles, LSB first, DATA_BITS samples.
  - Then go to PARITY if PARITY≠0, else STOP.
- PARITY:
  - One sample.
  - Parity error = (XOR of data bits XOR parity bit) ≠ (PARITY==1 ? 1 : 0).
- STOP:
  - STOP_BITS samples.
  - Framing error if any stop sample is 0.
  - On the final stop sample, push {tuser, data} to the FIFO and return to IDLE in the same cycle.
- Erroneous words are still delivered, with their flags set.
- FIFO and AXIS:
  - out_tvalid = !empty.
  - Pop on out_tvalid && out_tready.
  - out_tdata and out_tuser are stable while out_tvalid && !out_tready.
- Full FIFO:
  - A push with no simultaneous pop drops the incoming word and pulses overrun.
  - A push coinciding with a pop is accepted.

## Timing
- Reset values:
  - out_tvalid 0, out_tdata 0, out_tuser 0, overrun 0.
  - FIFO empty, FSM in IDLE, synchroniser stages at 1.
- Let E = the cycle the falling edge is seen at the synchroniser output (pin edge + 2 cycles).
- Sample k is taken at E + floor(CLKS_PER_BIT/2) + k·CLKS_PER_BIT:
  - k=0 is the start bit.
  - k=1..DATA_BITS are data bits.
  - Parity follows the data, then the stop bits.
- Into an empty FIFO, out_tvalid rises exactly 1 cycle after the final stop sample. There is no bypass path.
- overrun pulses in the cycle after the dropped push.
- Reset during a frame discards the partial frame and all FIFO contents; outputs take their reset values asynchronously.
- Throughput: back-to-back frames with no idle gap are received without loss, provided the FIFO drains.

## Structure
- Package uart_pkg holds:
  - the parity encodings PAR_NONE/PAR_ODD/PAR_EVEN;
  - the FSM state enum;
  - the tuser bit indices TUSER_PERR=0 and TUSER_FERR=1;
  - elaboration-time parameter legality checks.
- Sub-module axis_sync_fifo:
  - width DATA_BITS+2, depth FIFO_DEPTH;
  - push/full on the write side, AXIS valid/ready on the read side.
- The top level contains the synchroniser, bit-timing counter and FSM.

## Test plan
All scenarios use CLKS_PER_BIT=16, DATA_BITS=8, PARITY=2, STOP_BITS=1, FIFO_DEPTH=4, with out_tready=1 unless stated.
- Valid frame: send 0xA5 with even parity bit 0 → out_tdata=0xA5, out_tuser=00, out_tvalid high 1 cycle after the stop sample, for 1 cycle.
- Parity error: send 0xA5 with parity bit 1 → out_tdata=0xA5, out_tuser=01.
- Framing error: send 0x3C with stop bit 0, then hold rx low for 40 cycles → one word with out_tuser=10 and no further words until rx returns high and falls again.
- Glitch: rx low for 4 cycles, then high → no word, FSM back in IDLE, out_tvalid stays 0.
- Overrun: out_tready=0, send 0x01..0x05 → overrun pulses once, on the fifth word; after out_tready=1 the outputs are 0x01, 0x02, 0x03, 0x04, then out_tvalid=0.
- Reset mid-frame: assert aresetn=0 during data bit 3, release, then send 0x5A → exactly one word, 0x5A with out_tuser=00.
